// File: rtl/axis_pkg.sv
// Shared definitions for the 8-bit stream FIFO: data width, stored entry
// layout and a compile-time log2 helper.
package axis_pkg;

    localparam int AXIS_DATA_W = 8;

    // One stored word: end-of-packet flag above the payload byte.
    typedef struct packed {
        logic                   last;
        logic [AXIS_DATA_W-1:0] data;
    } axis_entry_t;

    // Ceiling log2, for deriving address widths from depths.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// One stream link: data/last qualified by valid, accepted by ready.
// A word transfers on a rising edge where valid && ready are both high.
// The master holds valid, data and last stable until the word is taken;
// ready may change freely and must never depend combinationally on valid.
interface axis_pkt_fifo_if;
    import axis_pkg::*;

    logic [AXIS_DATA_W-1:0] data;
    logic                   valid;
    logic                   ready;
    logic                   last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module fifo_mem
    import axis_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  axis_entry_t       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output axis_entry_t       rdata
);

    axis_entry_t mem [DEPTH];

    // Write port: store the entry on an accepted upstream word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Packet-aware stream FIFO. In store-and-forward mode the consumer only sees
// words once a complete packet is buffered, unless the FIFO fills without a
// stored last word, in which case the head is released (cut-through escape)
// so an oversize packet cannot deadlock the link. Read side is first-word
// fall-through; there is no write-to-read bypass and no full pass-through.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter bit STORE_FWD = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    axis_pkt_fifo_if.slave      s,
    axis_pkt_fifo_if.master     m,
    output logic [ADDR_W:0]     count,
    output logic [ADDR_W:0]     pkt_count
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ZERO    = '0;

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] pkt_q;

    logic        full;
    logic        empty;
    logic        wr_en;
    logic        rd_en;
    logic        out_valid;
    logic        pkt_inc;
    logic        pkt_dec;
    axis_entry_t wr_entry;
    axis_entry_t rd_entry;

    assign full  = (count_q == DEPTH_V);
    assign empty = (count_q == ZERO);

    // Upstream ready comes from the occupancy register only; it is held low
    // while reset is asserted so nothing is accepted into a FIFO being cleared.
    assign s.ready = !full && !reset;

    // Output gating: cut-through presents any stored word; store-and-forward
    // waits for a complete packet or for the full-without-last escape.
    always_comb begin
        out_valid = 1'b0;
        if (STORE_FWD) begin
            out_valid = !empty && ((pkt_q != ZERO) || full);
        end else begin
            out_valid = !empty;
        end
    end

    assign wr_en = s.valid && s.ready;
    assign rd_en = out_valid && m.ready;

    assign wr_entry.last = s.last;
    assign wr_entry.data = s.data;

    assign pkt_inc = wr_en && s.last;
    assign pkt_dec = rd_en && rd_entry.last;

    // Head word is shown only while valid so idle outputs read as zero.
    assign m.valid = out_valid;
    assign m.data  = out_valid ? rd_entry.data : '0;
    assign m.last  = out_valid && rd_entry.last;

    assign count     = count_q;
    assign pkt_count = pkt_q;

    fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rd_entry)
    );

    // Pointer and occupancy bookkeeping; pointers carry one extra wrap bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= ZERO;
            rd_ptr  <= ZERO;
            count_q <= ZERO;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Complete-packet counter: a stored last opens a packet for release,
    // reading a last word retires it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q <= ZERO;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_q <= pkt_q + ONE;
                2'b01:   pkt_q <= pkt_q - ONE;
                default: pkt_q <= pkt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: a store-and-forward instance carries most of the
// traffic against a queue of expected words; a cut-through instance covers
// the single-word latency case.
module tb_axis_pkt_fifo;
  import axis_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = clog2(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  axis_pkt_fifo_if sf_s ();
  axis_pkt_fifo_if sf_m ();
  axis_pkt_fifo_if ct_s ();
  axis_pkt_fifo_if ct_m ();

  logic [ADDR_W:0] sf_count;
  logic [ADDR_W:0] sf_pkt_count;
  logic [ADDR_W:0] ct_count;
  logic [ADDR_W:0] ct_pkt_count;

  axis_pkt_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STORE_FWD(1'b1)) u_sf (
    .clk       (clk),
    .reset     (reset),
    .s         (sf_s),
    .m         (sf_m),
    .count     (sf_count),
    .pkt_count (sf_pkt_count)
  );

  axis_pkt_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STORE_FWD(1'b0)) u_ct (
    .clk       (clk),
    .reset     (reset),
    .s         (ct_s),
    .m         (ct_m),
    .count     (ct_count),
    .pkt_count (ct_pkt_count)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic mon_en   = 1'b0;
  logic sf_watch = 1'b0;
  logic soak_on  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: every word the consumer takes must match the queue head.
  always @(negedge clk) begin
    logic [8:0] e;
    if (mon_en && !reset) begin
      if (sf_watch) check("sf_hold_valid", 32'(sf_m.valid), 32'd0);
      if (soak_on) begin
        check("count_max", 32'(sf_count <= 5'd16), 32'd1);
        check("pkt_count_max", 32'(sf_pkt_count <= 5'd16), 32'd1);
      end
      if (sf_m.valid && sf_m.ready) begin
        if (exp_q.size() == 0) begin
          check("sf_extra_word", {23'd0, sf_m.last, sf_m.data}, 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          check("sf_out_word", {23'd0, sf_m.last, sf_m.data}, {23'd0, e});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Presents one word to the store-and-forward FIFO and returns #1 after the
  // accepting edge with valid dropped; back-to-back calls give one word/cycle.
  task automatic send(input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    sf_s.valid = 1'b1;
    sf_s.data  = d;
    sf_s.last  = l;
    @(negedge clk);
    while (!sf_s.ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      check("send_timeout", 32'd1, 32'd0);
    end else begin
      @(posedge clk);
      exp_q.push_back({l, d});
    end
    #1;
    sf_s.valid = 1'b0;
    sf_s.last  = 1'b0;
    sf_s.data  = 8'h00;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1;
    sf_s.valid = 1'b0; sf_s.data = 8'h00; sf_s.last = 1'b0; sf_m.ready = 1'b0;
    ct_s.valid = 1'b0; ct_s.data = 8'h00; ct_s.last = 1'b0; ct_m.ready = 1'b0;

    // Reset / idle
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(sf_s.ready), 32'd0);
    check("rst_ct_s_ready", 32'(ct_s.ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_s_ready", 32'(sf_s.ready), 32'd1);
    check("idle_m_valid", 32'(sf_m.valid), 32'd0);
    check("idle_m_data", 32'(sf_m.data), 32'd0);
    check("idle_m_last", 32'(sf_m.last), 32'd0);
    check("idle_count", 32'(sf_count), 32'd0);
    check("idle_pkt_count", 32'(sf_pkt_count), 32'd0);
    check("idle_ct_m_valid", 32'(ct_m.valid), 32'd0);
    mon_en = 1'b1;

    // Store-and-forward packet
    @(posedge clk); #1;
    sf_m.ready = 1'b1;
    sf_watch = 1'b1;
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    send(8'h14, 1'b1);
    sf_watch = 1'b0;
    @(negedge clk);
    check("sf_valid_rise", 32'(sf_m.valid), 32'd1);
    check("sf_pkt_one", 32'(sf_pkt_count), 32'd1);
    check("sf_head_data", 32'(sf_m.data), 32'h11);
    wait_drain(8);
    check("sf_pkt_zero", 32'(sf_pkt_count), 32'd0);
    check("sf_count_zero", 32'(sf_count), 32'd0);
    check("sf_valid_fall", 32'(sf_m.valid), 32'd0);

    // Fill with non-last words under backpressure
    @(posedge clk); #1;
    sf_m.ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(8'(8'h40 + i), 1'b0);
    @(negedge clk);
    check("fill_count", 32'(sf_count), 32'd16);
    check("fill_s_ready", 32'(sf_s.ready), 32'd0);
    check("fill_escape_valid", 32'(sf_m.valid), 32'd1);
    check("fill_pkt_count", 32'(sf_pkt_count), 32'd0);
    check("fill_head_data", 32'(sf_m.data), 32'h40);
    @(posedge clk); #1;
    sf_m.ready = 1'b1;
    @(negedge clk);
    check("full_read_s_ready", 32'(sf_s.ready), 32'd0);
    @(posedge clk); #1;
    sf_m.ready = 1'b0;
    @(negedge clk);
    check("after_read_s_ready", 32'(sf_s.ready), 32'd1);
    check("after_read_count", 32'(sf_count), 32'd15);
    do_reset(1);

    // Cut-through single word
    @(negedge clk);
    check("ct_pre_valid", 32'(ct_m.valid), 32'd0);
    @(posedge clk); #1;
    ct_s.valid = 1'b1; ct_s.data = 8'hA5; ct_s.last = 1'b0;
    @(posedge clk); #1;
    ct_s.valid = 1'b0; ct_s.data = 8'h00;
    @(negedge clk);
    check("ct_valid", 32'(ct_m.valid), 32'd1);
    check("ct_data", 32'(ct_m.data), 32'hA5);
    check("ct_count", 32'(ct_count), 32'd1);

    // Mux-pattern soak
    @(posedge clk); #1;
    soak_on = 1'b1;
    fork
      begin
        int ph;
        ph = 0;
        while (soak_on) begin
          @(posedge clk); #1;
          sf_m.ready = (ph < 4);
          ph = (ph == 5) ? 0 : ph + 1;
        end
      end
    join_none
    for (int p = 0; p < 200; p++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int w = 0; w < len; w++) send(8'($urandom_range(0, 255)), (w == len - 1));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_drain(3000);
    soak_on = 1'b0;
    check("soak_count", 32'(sf_count), 32'd0);
    check("soak_pkt_count", 32'(sf_pkt_count), 32'd0);

    // Mid-packet reset
    @(posedge clk); #1;
    sf_m.ready = 1'b1;
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    do_reset(1);
    @(negedge clk);
    check("midrst_count", 32'(sf_count), 32'd0);
    check("midrst_pkt_count", 32'(sf_pkt_count), 32'd0);
    check("midrst_m_valid", 32'(sf_m.valid), 32'd0);
    @(posedge clk); #1;
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    send(8'h33, 1'b1);
    wait_drain(20);
    check("post_rst_count", 32'(sf_count), 32'd0);
    check("post_rst_valid", 32'(sf_m.valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    check("global_timeout", 32'd1, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
